// File: rtl/noise_test_sequencer.sv
// Sequences one noise-measurement window on the error counter:
// clear, count for a programmed window, then sample and judge.
module noise_test_sequencer #(
  parameter int CNT_W = 10,
  parameter int WIN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIN_W-1:0] window_len,
  input  logic [CNT_W-1:0] err_thresh,
  input  logic [CNT_W-1:0] err_count,
  output logic             cnt_reset,
  output logic             cnt_enable,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] result,
  output logic             pass,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    RUN,
    SAMPLE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIN_W-1:0] win_q;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] thr_q;
  logic [CNT_W-1:0] prev;
  logic             wrap;
  logic             wrap_now;
  logic             win_last;

  // The counter only steps by one, so any drop means it wrapped.
  assign wrap_now = wrap | (err_count < prev);
  assign win_last = (win_cnt == WIN_W'(1));

  always_comb begin
    state_nx   = state;
    cnt_reset  = 1'b0;
    cnt_enable = 1'b0;
    busy       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nx = CLEAR;
      end
      CLEAR: begin
        busy      = 1'b1;
        cnt_reset = 1'b1;
        state_nx  = abort ? IDLE : RUN;
      end
      RUN: begin
        busy       = 1'b1;
        cnt_enable = 1'b1;
        if (abort)         state_nx = IDLE;
        else if (win_last) state_nx = SAMPLE;
      end
      SAMPLE: begin
        busy     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_q    <= '0;
      win_cnt  <= '0;
      thr_q    <= '0;
      prev     <= '0;
      wrap     <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
      result   <= '0;
      pass     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= (state != IDLE) && abort;
      unique case (state)
        IDLE: begin
          if (start) begin
            win_q <= (window_len == '0) ? WIN_W'(1) : window_len;
            thr_q <= err_thresh;
            wrap  <= 1'b0;
          end
        end
        CLEAR: begin
          prev    <= '0;
          win_cnt <= win_q;
        end
        RUN: begin
          prev    <= err_count;
          wrap    <= wrap_now;
          win_cnt <= win_cnt - WIN_W'(1);
        end
        SAMPLE: begin
          prev <= err_count;
          wrap <= wrap_now;
          if (!abort) begin
            done <= 1'b1;
            if (wrap_now) begin
              result   <= '1;
              overflow <= 1'b1;
              pass     <= 1'b0;
            end else begin
              result   <= err_count;
              overflow <= 1'b0;
              pass     <= (err_count <= thr_q);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_noise_test_sequencer.sv
// Bench for noise_test_sequencer with a behavioural error counter
// and an arithmetic model of the window verdict.
module tb_noise_test_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic        err;
  logic [15:0] window_len;
  logic [9:0]  err_thresh;
  logic [9:0]  err_count;
  logic        cnt_reset;
  logic        cnt_enable;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [9:0]  result;
  logic        pass;
  logic        overflow;

  int vectors = 0;
  int miscompares = 0;
  bit pat [0:2047];
  logic [9:0] last_res = '0;
  bit last_pass = 1'b0;
  bit last_ovf = 1'b0;

  typedef struct {
    int         win;
    int         thr;
    int         mode;
    int         k;
    logic [9:0] res;
    bit         ps;
    bit         ov;
  } vec_t;

  vec_t tbl [9];

  always #5 clk = ~clk;

  noise_test_sequencer #(.CNT_W(10), .WIN_W(16)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .abort(abort),
    .window_len(window_len),
    .err_thresh(err_thresh),
    .err_count(err_count),
    .cnt_reset(cnt_reset),
    .cnt_enable(cnt_enable),
    .busy(busy),
    .done(done),
    .aborted(aborted),
    .result(result),
    .pass(pass),
    .overflow(overflow)
  );

  // Error counter: enable has priority over its reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_count <= '0;
    else if (cnt_enable) begin
      if (err) err_count <= err_count + 10'd1;
    end else if (cnt_reset) err_count <= '0;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fill_pat(input int mode, input int k, input int n);
    for (int i = 0; i < 2048; i++) pat[i] = 1'b0;
    case (mode)
      1: for (int i = 1; i <= n; i++) pat[i] = 1'b1;
      2: for (int j = 1; j <= k; j++) pat[2*j] = 1'b1;
      3: pat[n] = 1'b1;
      default: ;
    endcase
  endtask

  // Verdict from the total number of errors injected in the window.
  task automatic model(input int n, input int thr, output logic [9:0] r,
                       output bit p, output bit o);
    int total;
    total = 0;
    for (int i = 1; i <= n; i++) total += int'(pat[i]);
    o = (total >= 1024);
    r = o ? 10'd1023 : 10'(total);
    p = !o && (total <= thr);
  endtask

  task automatic measure(input int win, input int thr, input int abort_at,
                         input int spulse, input bit hold, input bit presta,
                         input bit ab0, input logic [9:0] eres,
                         input bit epass, input bit eovf);
    int n;
    n = (win == 0) ? 1 : win;
    if (!presta) @(negedge clk);
    start = 1'b1;
    window_len = 16'(win);
    err_thresh = 10'(thr);
    abort = ab0;
    err = 1'b0;
    @(posedge clk);
    for (int c = 0; c <= n + 2; c++) begin
      @(negedge clk);
      start = hold || (c == spulse);
      abort = 1'b0;
      err = 1'b0;
      chk("cnt_reset", 32'(cnt_reset), 32'(c == 0));
      chk("cnt_enable", 32'(cnt_enable), 32'(c >= 1 && c <= n));
      chk("busy", 32'(busy), 32'(c <= n + 1));
      chk("done", 32'(done), 32'(c == n + 2));
      chk("aborted", 32'(aborted), 32'(0));
      if (c == n + 2) begin
        chk("result", 32'(result), 32'(eres));
        chk("pass", 32'(pass), 32'(epass));
        chk("overflow", 32'(overflow), 32'(eovf));
        last_res = eres;
        last_pass = epass;
        last_ovf = eovf;
      end else begin
        chk("result_hold", 32'(result), 32'(last_res));
      end
      if (c == abort_at) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        chk("ab_pulse", 32'(aborted), 32'(1));
        chk("ab_busy", 32'(busy), 32'(0));
        chk("ab_en", 32'(cnt_enable), 32'(0));
        chk("ab_clr", 32'(cnt_reset), 32'(0));
        chk("ab_done", 32'(done), 32'(0));
        chk("ab_result", 32'(result), 32'(last_res));
        chk("ab_pass", 32'(pass), 32'(last_pass));
        chk("ab_ovf", 32'(overflow), 32'(last_ovf));
        @(negedge clk);
        chk("ab_once", 32'(aborted), 32'(0));
        chk("ab_idle", 32'(busy), 32'(0));
        return;
      end
      if (c >= 1 && c <= n) err = pat[c];
    end
    if (!hold) start = 1'b0;
    if (spulse >= 0) begin
      @(negedge clk);
      chk("single_busy", 32'(busy), 32'(0));
      chk("single_done", 32'(done), 32'(0));
    end
  endtask

  initial begin
    logic [9:0] r;
    bit p;
    bit o;
    int win;
    int thr;
    int dens;
    int ab;
    int sp;

    tbl[0] = '{8, 5, 2, 3, 10'd3, 1'b1, 1'b0};
    tbl[1] = '{8, 2, 2, 3, 10'd3, 1'b0, 1'b0};
    tbl[2] = '{8, 3, 2, 3, 10'd3, 1'b1, 1'b0};
    tbl[3] = '{1100, 1023, 1, 0, 10'd1023, 1'b0, 1'b1};
    tbl[4] = '{4, 0, 0, 0, 10'd0, 1'b1, 1'b0};
    tbl[5] = '{0, 0, 1, 0, 10'd1, 1'b0, 1'b0};
    tbl[6] = '{6, 0, 3, 0, 10'd1, 1'b0, 1'b0};
    tbl[7] = '{1024, 1023, 1, 0, 10'd1023, 1'b0, 1'b1};
    tbl[8] = '{1023, 1023, 1, 0, 10'd1023, 1'b1, 1'b0};

    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    err = 1'b0;
    window_len = '0;
    err_thresh = '0;
    repeat (2) @(negedge clk);
    chk("rst_clr", 32'(cnt_reset), 32'(0));
    chk("rst_en", 32'(cnt_enable), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_result", 32'(result), 32'(0));
    chk("rst_pass", 32'(pass), 32'(0));
    chk("rst_ovf", 32'(overflow), 32'(0));
    reset = 1'b0;

    foreach (tbl[i]) begin
      fill_pat(tbl[i].mode, tbl[i].k, (tbl[i].win == 0) ? 1 : tbl[i].win);
      measure(tbl[i].win, tbl[i].thr, -1, -1, 1'b0, 1'b0, 1'b0,
              tbl[i].res, tbl[i].ps, tbl[i].ov);
    end

    // Abort on the third RUN cycle, then a zero-length window.
    fill_pat(1, 0, 10);
    measure(10, 5, 3, -1, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0);
    fill_pat(0, 0, 1);
    measure(0, 0, -1, -1, 1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 1'b0);

    // Abort together with start in IDLE: start wins.
    fill_pat(2, 2, 5);
    measure(5, 1, -1, -1, 1'b0, 1'b0, 1'b1, 10'd2, 1'b0, 1'b0);

    // Abort in CLEAR and in SAMPLE.
    fill_pat(1, 0, 5);
    measure(5, 9, 0, -1, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0);
    measure(5, 9, 6, -1, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0);

    // Start held high: second run launches right after done.
    fill_pat(1, 0, 3);
    measure(3, 3, -1, -1, 1'b1, 1'b0, 1'b0, 10'd3, 1'b1, 1'b0);
    fill_pat(0, 0, 2);
    measure(2, 0, -1, -1, 1'b0, 1'b1, 1'b0, 10'd0, 1'b1, 1'b0);

    // Start pulsed during RUN is ignored.
    fill_pat(2, 2, 6);
    measure(6, 1, -1, 3, 1'b0, 1'b0, 1'b0, 10'd2, 1'b0, 1'b0);

    // Asynchronous reset between edges mid-RUN.
    @(negedge clk);
    start = 1'b1;
    window_len = 16'd10;
    err_thresh = 10'd5;
    err = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_en", 32'(cnt_enable), 32'(1));
    #3 reset = 1'b1;
    #1;
    chk("arst_en", 32'(cnt_enable), 32'(0));
    chk("arst_busy", 32'(busy), 32'(0));
    chk("arst_clr", 32'(cnt_reset), 32'(0));
    chk("arst_result", 32'(result), 32'(0));
    chk("arst_pass", 32'(pass), 32'(0));
    chk("arst_ovf", 32'(overflow), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    err = 1'b0;
    last_res = '0;
    last_pass = 1'b0;
    last_ovf = 1'b0;
    fill_pat(2, 3, 8);
    measure(8, 5, -1, -1, 1'b0, 1'b0, 1'b0, 10'd3, 1'b1, 1'b0);

    for (int it = 0; it < 40; it++) begin
      int n;
      win = int'($urandom_range(0, 40));
      thr = int'($urandom_range(0, 30));
      dens = int'($urandom_range(0, 4));
      n = (win == 0) ? 1 : win;
      for (int i = 0; i < 2048; i++) pat[i] = 1'b0;
      for (int i = 1; i <= n; i++)
        pat[i] = (int'($urandom_range(0, 3)) < dens);
      model(n, thr, r, p, o);
      ab = -1;
      sp = -1;
      if ($urandom_range(0, 5) == 0) ab = int'($urandom_range(0, n + 1));
      if ($urandom_range(0, 5) == 0) sp = int'($urandom_range(1, n));
      measure(win, thr, ab, sp, 1'b0, 1'b0, 1'($urandom_range(0, 1)),
              r, p, o);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
